// File: rtl/gate_sweep_checker.sv
// Exhaustive a/b sweep driver and checker for an external and/or/xor block.
// Optional first-failure capture ports: define GATE_SWEEP_CAPTURE_EN.
module gate_sweep_checker #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] and_i,
  input  logic [WIDTH-1:0] or_i,
  input  logic [WIDTH-1:0] xor_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_SWEEP_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
`endif
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (SETTLE_CYC > 1) ?
                      $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t           state_q;
  logic [VW-1:0]    vec_q;
  logic [CW-1:0]    cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             mism;

`ifdef GATE_SWEEP_CAPTURE_EN
  logic             fv_q;
  logic [WIDTH-1:0] fa_q;
  logic [WIDTH-1:0] fb_q;

  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
`endif

  assign a_o       = vec_q[VW-1:WIDTH];
  assign b_o       = vec_q[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

  always_comb begin
    mism = (and_i != (a_o & b_o)) ||
           (or_i  != (a_o | b_o)) ||
           (xor_i != (a_o ^ b_o));
    err_d = (&err_q) ? err_q : err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GATE_SWEEP_CAPTURE_EN
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SETTLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef GATE_SWEEP_CAPTURE_EN
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
`endif
          end
        end
        SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (mism) begin
            err_q <= err_d;
`ifdef GATE_SWEEP_CAPTURE_EN
            if (!fv_q) begin
              fv_q <= 1'b1;
              fa_q <= a_o;
              fb_q <= b_o;
            end
`endif
          end
          // Final vector: stop without wrapping vec.
          if (&vec_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !mism && (err_q == '0);
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= SETTLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: fault-injecting gate models, sweep-level
// reference counts, latency, reset abort, start filtering, saturation.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic s1 = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail = 0;
  int mode = 0;
  int mode1 = 0;
  logic       bad [256];
  logic [3:0] msk [256];

  logic [3:0] a, b, andv, orv, xorv;
  logic       busy, done, pass;
  logic [7:0] err;
  logic [1:0] a1, b1, and1, or1, xor1;
  logic       busy1, done1, pass1;
  logic [3:0] err1;
  logic [5:0] p1, p2;
`ifdef GATE_SWEEP_CAPTURE_EN
  logic       fv, fv1;
  logic [3:0] fa, fb;
  logic [1:0] fa1, fb1;
`endif

  function automatic logic [11:0] gate(
    input logic [3:0] x, input logic [3:0] y, input int md);
    logic [3:0] an, o, xo;
    an = x & y;
    o  = x | y;
    xo = x ^ y;
    case (md)
      1: xo[0] = 1'b0;
      2: an = ~an;
      3: if (bad[{x, y}]) o = o ^ msk[{x, y}];
      default: ;
    endcase
    return {an, o, xo};
  endfunction

  assign {andv, orv, xorv} = gate(a, b, mode);

  always @(posedge clk) begin
    p1 <= {a1 & b1, a1 | b1, a1 ^ b1};
    p2 <= p1;
  end

  assign {and1, or1, xor1} =
    (mode1 == 0) ? p1 :
    (mode1 == 1) ? p2 :
    {~(a1 & b1), a1 | b1, a1 ^ b1};

  gate_sweep_checker #(.WIDTH(4), .SETTLE_CYC(2), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a), .b_o(b),
    .and_i(andv), .or_i(orv), .xor_i(xorv),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err)
`ifdef GATE_SWEEP_CAPTURE_EN
    , .fail_valid(fv), .fail_a(fa), .fail_b(fb)
`endif
  );

  gate_sweep_checker #(.WIDTH(2), .SETTLE_CYC(1), .ERR_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1),
    .a_o(a1), .b_o(b1),
    .and_i(and1), .or_i(or1), .xor_i(xor1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1)
`ifdef GATE_SWEEP_CAPTURE_EN
    , .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected saturated mismatch count and first failing index of a sweep.
  function automatic int ref_errs(input int md, input int lim,
                                  output int first);
    int n;
    logic [3:0] x, y;
    n = 0;
    first = 0;
    for (int i = 0; i < 256; i++) begin
      x = i[7:4];
      y = i[3:0];
      if (gate(x, y, md) != {x & y, x | y, x ^ y}) begin
        if (n == 0) first = i;
        n++;
      end
    end
    return (n > lim) ? lim : n;
  endfunction

  task automatic sweep0(input bit noisy, output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check("busy_rise", busy, 1);
    check("clr_done", done, 0);
    check("clr_err", err, 0);
    check("first_ab", {a, b}, 0);
    while (!done && cyc < 2000) begin
      start = noisy && ($urandom_range(0, 5) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic sweep1(output int cyc);
    s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    cyc = 1;
    check("u1_busy", busy1, 1);
    while (!done1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic full0(input string tag, input int md, input bit noisy);
    int cyc, first, exp;
    mode = md;
    exp = ref_errs(md, 255, first);
    sweep0(noisy, cyc);
    check({tag, "_lat"}, cyc, 769);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, exp);
    check({tag, "_pass"}, pass, (exp == 0));
`ifdef GATE_SWEEP_CAPTURE_EN
    check({tag, "_fv"}, fv, (exp != 0));
    check({tag, "_fab"}, {fa, fb}, first);
`endif
  endtask

  initial begin
    int cyc, k;
    logic [7:0] held;
    for (int i = 0; i < 256; i++) begin
      bad[i] = ($urandom_range(0, 9) == 0);
      msk[i] = 4'($urandom_range(1, 15));
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_ab", {a, b}, 0);
    check("rst_flags", {busy, done, pass}, 0);
    check("rst_err", err, 0);
`ifdef GATE_SWEEP_CAPTURE_EN
    check("rst_fv", fv, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_flags", {busy, done, pass}, 0);

    full0("good", 0, 1'b0);
    full0("xor0", 1, 1'b0);
    check("xor0_128", err, 128);
    full0("andinv", 2, 1'b0);
    full0("rand", 3, 1'b1);

    held = err;
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", {busy, done}, 2'b01);
    check("hold_err", err, held);

    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while ({a, b} != 8'd100 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_v100", {a, b}, 100);
    rst_n = 1'b0;
    #1;
    check("abort_ab", {a, b}, 0);
    check("abort_flags", {busy, done, pass}, 0);
    check("abort_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    full0("after_rst", 0, 1'b0);

    mode1 = 0;
    sweep1(cyc);
    check("u1_lat", cyc, 33);
    check("u1_reg1_pass", {done1, pass1}, 2'b11);
    check("u1_reg1_err", err1, 0);
    mode1 = 1;
    sweep1(cyc);
    check("u1_reg2_errnz", (err1 != 0), 1);
    check("u1_reg2_pass", pass1, 0);
    mode1 = 2;
    sweep1(cyc);
    check("u1_sat_err", err1, 15);
    check("u1_sat_pass", {done1, pass1}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
